// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared sizes and FSM state encodings for the IMem loader.
//   IMEM_SIZE_DEF  default instruction memory depth in 32-bit words
//   CNT_W_DEF      default width of the frame word-count field
//   S_*            FSM state encodings
//   rx_state()     true in states that accept a byte
package imem_loader_pkg;
    localparam int IMEM_SIZE_DEF = 256;
    localparam int CNT_W_DEF = 16;
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEN_HI = 3'd1;
    localparam logic [2:0] S_LEN_LO = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_WRITE  = 3'd4;
    localparam logic [2:0] S_CSUM   = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;
    localparam logic [2:0] S_ERR    = 3'd7;
    function automatic logic rx_state(input logic [2:0] s);
        return s inside {S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM};
    endfunction
endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream receive handshake plus IMem write port.
//   RX_DATA/RX_VALID/RX_READY  byte stream, transfer = RX_VALID & RX_READY
//   LOAD_WE/LOAD_ADDR/LOAD_INS IMem write strobe, byte address, instruction word
//   master: the loader side, slave: the environment (receiver + IMem)
interface imem_loader_if;
    logic [7:0]  RX_DATA;
    logic        RX_VALID;
    logic        RX_READY;
    logic        LOAD_WE;
    logic [31:0] LOAD_ADDR;
    logic [31:0] LOAD_INS;
    modport master (input RX_DATA, RX_VALID, output RX_READY, LOAD_WE, LOAD_ADDR, LOAD_INS);
    modport slave (output RX_DATA, RX_VALID, input RX_READY, LOAD_WE, LOAD_ADDR, LOAD_INS);
endinterface

// File: rtl/imem_loader_word_asm.sv
// imem_loader_word_asm: assembles four bytes, MSB first, into a 32-bit word.
//   CLK, RST_N  clock, synchronous active-low reset
//   clr         restart assembly at byte 0
//   shift       accept byte_in
//   byte_in     incoming byte
//   word_next   word formed by the held bytes plus byte_in
//   word_ready  byte_in completes a word this cycle
module imem_loader_word_asm (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        clr,
    input  logic        shift,
    input  logic [7:0]  byte_in,
    output logic [31:0] word_next,
    output logic        word_ready
);
    logic [23:0] sr;
    logic [1:0]  cnt;
    assign word_next = {sr, byte_in};
    assign word_ready = shift && cnt == 2'd3;
    always_ff @(posedge CLK) begin
        if (!RST_N || clr) begin
            sr  <= '0;
            cnt <= '0;
        end else if (shift) begin
            sr  <= word_next[23:0];
            cnt <= cnt + 2'd1;
        end
    end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: frames a byte stream into IMem writes and holds the core in reset while loading.
//   CLK, RST_N  clock, synchronous active-low reset
//   START       arm a new load (honoured in IDLE, DONE or ERR)
//   bus         receive handshake and IMem write port (master side)
//   CPU_RST     core reset request, high while a frame is loading or rejected
//   DONE, ERR   sticky frame outcome, cleared by START or reset
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int IMEM_SIZE = IMEM_SIZE_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         START,
    imem_loader_if.master bus,
    output logic         CPU_RST,
    output logic         DONE,
    output logic         ERR
);
    logic [2:0]       state;
    logic [CNT_W-1:0] n;
    logic [CNT_W-1:0] idx;
    logic [CNT_W-1:0] n_next;
    logic [7:0]       xsum;
    logic             acc;
    logic             arm;
    logic [31:0]      word_next;
    logic             word_ready;
    assign bus.RX_READY = rx_state(state);
    assign bus.LOAD_WE = state == S_WRITE;
    assign acc = bus.RX_VALID && rx_state(state);
    assign arm = START && state inside {S_IDLE, S_DONE, S_ERR};
    assign n_next = {n[CNT_W-9:0], bus.RX_DATA};
    imem_loader_word_asm u_asm (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .clr       (arm),
        .shift     (acc && state == S_DATA),
        .byte_in   (bus.RX_DATA),
        .word_next (word_next),
        .word_ready(word_ready)
    );
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state         <= S_IDLE;
            n             <= '0;
            idx           <= '0;
            xsum          <= '0;
            bus.LOAD_ADDR <= '0;
            bus.LOAD_INS  <= '0;
            CPU_RST       <= 1'b0;
            DONE          <= 1'b0;
            ERR           <= 1'b0;
        end else begin
            // the checksum byte itself never enters the accumulator
            if (acc && state != S_CSUM) xsum <= xsum ^ bus.RX_DATA;
            case (state)
                S_IDLE, S_DONE, S_ERR: if (START) begin
                    state   <= S_LEN_HI;
                    DONE    <= 1'b0;
                    ERR     <= 1'b0;
                    CPU_RST <= 1'b1;
                    idx     <= '0;
                    xsum    <= '0;
                end
                S_LEN_HI: if (acc) begin
                    n     <= CNT_W'(bus.RX_DATA);
                    state <= S_LEN_LO;
                end
                S_LEN_LO: if (acc) begin
                    n <= n_next;
                    if (n_next > CNT_W'(IMEM_SIZE)) begin
                        state <= S_ERR;
                        ERR   <= 1'b1;
                    end else begin
                        state <= n_next == '0 ? S_CSUM : S_DATA;
                    end
                end
                // capture the write payload on the 4th byte so it is stable during WRITE
                S_DATA: if (word_ready) begin
                    state         <= S_WRITE;
                    bus.LOAD_INS  <= word_next;
                    bus.LOAD_ADDR <= {{(30-CNT_W){1'b0}}, idx, 2'b00};
                end
                S_WRITE: begin
                    idx   <= idx + 1'b1;
                    state <= idx + 1'b1 == n ? S_CSUM : S_DATA;
                end
                S_CSUM: if (acc) begin
                    if (bus.RX_DATA == xsum) begin
                        state   <= S_DONE;
                        DONE    <= 1'b1;
                        CPU_RST <= 1'b0;
                    end else begin
                        state <= S_ERR;
                        ERR   <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table-driven directed bench for imem_loader.
module tb_imem_loader;
    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    logic START = 1'b0;
    logic CPU_RST, DONE, ERR;
    imem_loader_if bus();
    imem_loader dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .START  (START),
        .bus    (bus.master),
        .CPU_RST(CPU_RST),
        .DONE   (DONE),
        .ERR    (ERR)
    );
    always #5 CLK = ~CLK;

    localparam logic [31:0] W1 = 32'h20080005;
    localparam logic [31:0] W2 = 32'h8C010000;

    typedef struct {
        string       name;
        logic        start;
        logic        rst_n;
        logic        valid;
        logic [7:0]  data;
        logic [68:0] exp;
    } vec_t;
    vec_t vq[$];

    int n_cmp = 0;
    int n_err = 0;
    int we_cnt = 0;
    logic [31:0] last_addr = '0;
    logic [31:0] last_ins = '0;

    always @(posedge CLK)
        if (bus.LOAD_WE === 1'b1) begin
            we_cnt++;
            last_addr = bus.LOAD_ADDR;
            last_ins = bus.LOAD_INS;
        end

    // {RX_READY, LOAD_WE, LOAD_ADDR, LOAD_INS, CPU_RST, DONE, ERR}
    function automatic logic [68:0] outs();
        return {bus.RX_READY, bus.LOAD_WE, bus.LOAD_ADDR, bus.LOAD_INS, CPU_RST, DONE, ERR};
    endfunction

    task automatic check(input string nm, input logic [68:0] act, input logic [68:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic void add(input string nm, input logic st, input logic rn, input logic vl,
                                input logic [7:0] d, input logic rdy, input logic we,
                                input logic [31:0] a, input logic [31:0] ins,
                                input logic cpu, input logic dn, input logic er);
        vq.push_back('{name: nm, start: st, rst_n: rn, valid: vl, data: d,
                       exp: {rdy, we, a, ins, cpu, dn, er}});
    endfunction

    // each vector: inputs applied after negedge, outputs checked before the next posedge
    task automatic run_vecs();
        foreach (vq[i]) begin
            @(negedge CLK);
            START = vq[i].start;
            RST_N = vq[i].rst_n;
            bus.RX_VALID = vq[i].valid;
            bus.RX_DATA = vq[i].data;
            #1;
            check($sformatf("%s[%0d]", vq[i].name, i), outs(), vq[i].exp);
        end
        vq.delete();
        @(negedge CLK);
        START = 1'b0;
        RST_N = 1'b1;
        bus.RX_VALID = 1'b0;
    endtask

    // two-word frame 00 02 | 20 08 00 05 | 8C 01 00 00 | cs, starting from held a0/i0
    task automatic frame_vecs(input string nm, input logic [7:0] cs, input logic [31:0] a0,
                              input logic [31:0] i0, input logic cpu0, input logic d0,
                              input logic e0, input logic good);
        logic [7:0] hdr [6];
        logic [7:0] w2b [4];
        hdr = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05};
        w2b = '{8'h8C, 8'h01, 8'h00, 8'h00};
        add(nm, 1, 1, 0, 8'h00, 0, 0, a0, i0, cpu0, d0, e0);
        foreach (hdr[k]) add(nm, 0, 1, 1, hdr[k], 1, 0, a0, i0, 1, 0, 0);
        add(nm, 0, 1, 1, 8'h8C, 0, 1, 32'h0, W1, 1, 0, 0);
        foreach (w2b[k]) add(nm, 0, 1, 1, w2b[k], 1, 0, 32'h0, W1, 1, 0, 0);
        add(nm, 0, 1, 1, cs, 0, 1, 32'h4, W2, 1, 0, 0);
        add(nm, 0, 1, 1, cs, 1, 0, 32'h4, W2, 1, 0, 0);
        add(nm, 0, 1, 0, 8'h00, 0, 0, 32'h4, W2, !good, good, !good);
        add(nm, 0, 1, 1, 8'h55, 0, 0, 32'h4, W2, !good, good, !good);
    endtask

    task automatic send_byte(input logic [7:0] d);
        int k = 0;
        @(negedge CLK);
        bus.RX_VALID = 1'b1;
        bus.RX_DATA = d;
        #1;
        while (!bus.RX_READY && k < 20) begin
            @(negedge CLK);
            #1;
            k++;
        end
        if (!bus.RX_READY) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_byte: RX_READY stuck at 0 for byte %h", d);
        end
        @(posedge CLK);
        #1 bus.RX_VALID = 1'b0;
    endtask

    initial begin
        logic [7:0] xs;
        logic [7:0] i8;
        logic [31:0] w;
        bus.RX_VALID = 1'b1;
        bus.RX_DATA = 8'hFF;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("reset_outputs", outs(), '0);
        RST_N = 1'b1;
        @(negedge CLK);
        #1;
        check("idle_no_ready", outs(), '0);

        frame_vecs("good", 8'hA2, 32'h0, 32'h0, 0, 0, 0, 1);
        run_vecs();
        check("good_we_cnt", 69'(we_cnt), 69'(2));

        frame_vecs("badcs", 8'h0B, 32'h4, W2, 0, 1, 0, 0);
        run_vecs();
        check("badcs_we_cnt", 69'(we_cnt), 69'(4));

        add("over", 1, 1, 0, 8'h00, 0, 0, 32'h4, W2, 1, 0, 1);
        add("over", 0, 1, 1, 8'h01, 1, 0, 32'h4, W2, 1, 0, 0);
        add("over", 0, 1, 1, 8'h01, 1, 0, 32'h4, W2, 1, 0, 0);
        add("over", 0, 1, 1, 8'h00, 0, 0, 32'h4, W2, 1, 0, 1);
        add("over", 0, 1, 1, 8'h00, 0, 0, 32'h4, W2, 1, 0, 1);
        run_vecs();
        check("over_we_cnt", 69'(we_cnt), 69'(4));

        add("empty", 1, 1, 0, 8'h00, 0, 0, 32'h4, W2, 1, 0, 1);
        for (int k = 0; k < 3; k++) begin
            repeat (3) add("empty", 0, 1, 0, 8'hEE, 1, 0, 32'h4, W2, 1, 0, 0);
            add("empty", 0, 1, 1, 8'h00, 1, 0, 32'h4, W2, 1, 0, 0);
        end
        add("empty", 0, 1, 0, 8'h00, 0, 0, 32'h4, W2, 0, 1, 0);
        add("empty", 0, 1, 1, 8'h00, 0, 0, 32'h4, W2, 0, 1, 0);
        run_vecs();
        check("empty_we_cnt", 69'(we_cnt), 69'(4));

        add("rstmid", 1, 1, 0, 8'h00, 0, 0, 32'h4, W2, 0, 1, 0);
        add("rstmid", 0, 1, 1, 8'h00, 1, 0, 32'h4, W2, 1, 0, 0);
        add("rstmid", 0, 1, 1, 8'h02, 1, 0, 32'h4, W2, 1, 0, 0);
        add("rstmid", 1, 1, 1, 8'hAA, 1, 0, 32'h4, W2, 1, 0, 0);
        add("rstmid", 1, 1, 1, 8'hBB, 1, 0, 32'h4, W2, 1, 0, 0);
        add("rstmid", 0, 1, 1, 8'hCC, 1, 0, 32'h4, W2, 1, 0, 0);
        add("rstmid", 0, 1, 1, 8'hDD, 1, 0, 32'h4, W2, 1, 0, 0);
        add("rstmid", 0, 1, 0, 8'h00, 0, 1, 32'h0, 32'hAABBCCDD, 1, 0, 0);
        add("rstmid", 0, 1, 1, 8'h11, 1, 0, 32'h0, 32'hAABBCCDD, 1, 0, 0);
        add("rstmid", 0, 1, 1, 8'h22, 1, 0, 32'h0, 32'hAABBCCDD, 1, 0, 0);
        add("rstmid", 0, 0, 0, 8'h00, 1, 0, 32'h0, 32'hAABBCCDD, 1, 0, 0);
        add("rstmid", 1, 1, 1, 8'h33, 0, 0, 32'h0, 32'h0, 0, 0, 0);
        add("rstmid", 0, 1, 1, 8'h00, 1, 0, 32'h0, 32'h0, 1, 0, 0);
        add("rstmid", 0, 1, 1, 8'h01, 1, 0, 32'h0, 32'h0, 1, 0, 0);
        add("rstmid", 0, 1, 1, 8'h12, 1, 0, 32'h0, 32'h0, 1, 0, 0);
        add("rstmid", 0, 1, 1, 8'h34, 1, 0, 32'h0, 32'h0, 1, 0, 0);
        add("rstmid", 0, 1, 1, 8'h56, 1, 0, 32'h0, 32'h0, 1, 0, 0);
        add("rstmid", 0, 1, 1, 8'h78, 1, 0, 32'h0, 32'h0, 1, 0, 0);
        add("rstmid", 0, 1, 0, 8'h00, 0, 1, 32'h0, 32'h12345678, 1, 0, 0);
        add("rstmid", 0, 1, 1, 8'h09, 1, 0, 32'h0, 32'h12345678, 1, 0, 0);
        add("rstmid", 0, 1, 0, 8'h00, 0, 0, 32'h0, 32'h12345678, 0, 1, 0);
        run_vecs();
        check("rstmid_we_cnt", 69'(we_cnt), 69'(6));

        @(negedge CLK);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        send_byte(8'h01);
        send_byte(8'h00);
        xs = 8'h01;
        w = '0;
        for (int i = 0; i < 256; i++) begin
            i8 = 8'(i);
            w = {i8, ~i8, 8'h5A, i8 ^ 8'h3C};
            for (int b = 3; b >= 0; b--) begin
                xs ^= w[b*8 +: 8];
                send_byte(w[b*8 +: 8]);
            end
        end
        send_byte(xs);
        @(negedge CLK);
        #1;
        check("full_done", outs(), {1'b0, 1'b0, 32'h3FC, w, 1'b0, 1'b1, 1'b0});
        check("full_we_cnt", 69'(we_cnt), 69'(262));
        check("full_last_addr", 69'(last_addr), 69'(32'h3FC));
        check("full_last_ins", 69'(last_ins), 69'(w));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
        $fatal(1, "watchdog expired");
    end
endmodule
